// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-side arbiter and its round-robin picker.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after last_ptr, modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_ptr,
  output logic [IDW-1:0]  winner,
  output logic            any_req
);

  always_comb begin
    winner  = '0;
    any_req = |req;
    // Scan from the farthest offset down so the nearest request after last_ptr wins.
    for (int unsigned k = NREQ; k > 0; k--) begin
      if (req[(32'(last_ptr) + k) % NREQ]) begin
        winner = IDW'((32'(last_ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ valid/ready producers.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned IDW       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_wea,
  output logic [DATA_W-1:0]      fifo_dina,
  output logic                   grant_active,
  output logic [IDW-1:0]         grant_id
);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] last_ptr_q, last_ptr_d;
  logic [7:0]     beat_cnt_q, beat_cnt_d;
  logic [IDW-1:0] winner;
  logic           any_req;
  logic           beat;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req      (req_valid),
    .last_ptr (last_ptr_q),
    .winner   (winner),
    .any_req  (any_req)
  );

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_ptr_d   = last_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    req_ready    = '0;
    fifo_wea     = 1'b0;
    fifo_dina    = '0;
    grant_active = 1'b0;
    beat         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_id_d = winner;
          beat_cnt_d = '0;
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        grant_active          = 1'b1;
        req_ready[grant_id_q] = ~fifo_full;
        fifo_dina             = req_data[int'(grant_id_q)*DATA_W +: DATA_W];
        beat                  = req_valid[grant_id_q] & ~fifo_full;
        fifo_wea              = beat;
        // Full alone stalls; only a dropped valid or the final beat releases.
        if (!req_valid[grant_id_q] ||
            (beat && beat_cnt_q == 8'(MAX_BURST - 1))) begin
          last_ptr_d = grant_id_q;
          beat_cnt_d = '0;
          state_d    = ST_IDLE;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_id_q <= '0;
      last_ptr_q <= IDW'(NREQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_ptr_q <= last_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_fifo_wr_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic            fifo_full;
  logic            fifo_wea;
  logic [DW-1:0]   fifo_dina;
  logic            grant_active;
  logic [1:0]      grant_id;

  int nchk = 0;
  int nbad = 0;

  fifo_wr_arbiter #(
    .NREQ      (4),
    .DATA_W    (16),
    .MAX_BURST (8),
    .IDW       (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wea     (fifo_wea),
    .fifo_dina    (fifo_dina),
    .grant_active (grant_active),
    .grant_id     (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic        full;
    logic [15:0] d0;
    logic        act;
    logic [1:0]  gid;
    logic        wea;
    logic [3:0]  rdy;
    logic [15:0] dina;
  } vec_t;

  vec_t vecs[14];

  // Checks outputs mid-cycle against expected values; grant_id only matters while active.
  task automatic chk(input string name, input logic act, input logic [1:0] gid,
                     input logic wea, input logic [3:0] rdy, input logic [15:0] dina);
    #1;
    nchk++;
    if ({grant_active, fifo_wea, req_ready, fifo_dina} !== {act, wea, rdy, dina} ||
        (act && grant_id !== gid)) begin
      nbad++;
      $display("FAIL %s: got act=%b gid=%0d wea=%b rdy=%b dina=%h, want act=%b gid=%0d wea=%b rdy=%b dina=%h",
               name, grant_active, grant_id, fifo_wea, req_ready, fifo_dina,
               act, gid, wea, rdy, dina);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic f, input logic [15:0] d0,
                              input logic a, input logic [1:0] g, input logic w,
                              input logic [3:0] r, input logic [15:0] dn);
    vec_t x;
    x.valid = v; x.full = f; x.d0 = d0; x.act = a; x.gid = g;
    x.wea = w; x.rdy = r; x.dina = dn;
    return x;
  endfunction

  int wr_cnt;
  logic [1:0] order[5];

  initial begin
    rst = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;
    req_data = {16'h4000, 16'h3000, 16'h2000, 16'h1000};

    // Reset state
    tick();
    chk("reset_outputs", 1'b0, 2'd0, 1'b0, 4'b0000, 16'h0000);
    tick();
    rst = 1'b0;

    // Test 1: single requester, 10 words -> burst of 8, gap, then 2
    vecs[0] = mk(4'b0001, 1'b0, 16'h1000, 1'b0, 2'd0, 1'b0, 4'b0000, 16'h0000);
    for (int unsigned k = 1; k <= 8; k++)
      vecs[k] = mk(4'b0001, 1'b0, 16'h1000 + 16'(k - 1), 1'b1, 2'd0, 1'b1, 4'b0001,
                   16'h1000 + 16'(k - 1));
    vecs[9]  = mk(4'b0001, 1'b0, 16'h1008, 1'b0, 2'd0, 1'b0, 4'b0000, 16'h0000);
    vecs[10] = mk(4'b0001, 1'b0, 16'h1008, 1'b1, 2'd0, 1'b1, 4'b0001, 16'h1008);
    vecs[11] = mk(4'b0001, 1'b0, 16'h1009, 1'b1, 2'd0, 1'b1, 4'b0001, 16'h1009);
    vecs[12] = mk(4'b0000, 1'b0, 16'h100A, 1'b1, 2'd0, 1'b0, 4'b0001, 16'h100A);
    vecs[13] = mk(4'b0000, 1'b0, 16'h100A, 1'b0, 2'd0, 1'b0, 4'b0000, 16'h0000);
    for (int i = 0; i < 14; i++) begin
      req_valid = vecs[i].valid;
      fifo_full = vecs[i].full;
      req_data[15:0] = vecs[i].d0;
      chk($sformatf("t1_vec%0d", i), vecs[i].act, vecs[i].gid, vecs[i].wea,
          vecs[i].rdy, vecs[i].dina);
      tick();
    end
    req_data[15:0] = 16'h1000;

    // Test 2: all valid -> order 0,1,2,3,0 with one gap cycle per burst
    do_reset();
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req_valid = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      chk($sformatf("t2_gap%0d", b), 1'b0, 2'd0, 1'b0, 4'b0000, 16'h0000);
      tick();
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("t2_b%0d_beat%0d", b, k), 1'b1, order[b], 1'b1,
            4'(1 << order[b]), 16'h1000 * (16'(order[b]) + 16'd1));
        tick();
      end
    end

    // Test 3: req 2, full for 5 cycles after beat 3, then resume to 8 beats
    do_reset();
    req_valid = 4'b0100;
    wr_cnt = 0;
    chk("t3_arb", 1'b0, 2'd0, 1'b0, 4'b0000, 16'h0000);
    tick();
    for (int k = 0; k < 13; k++) begin
      fifo_full = (k >= 3 && k < 8);
      if (fifo_full) chk($sformatf("t3_stall%0d", k), 1'b1, 2'd2, 1'b0, 4'b0000, 16'h3000);
      else           chk($sformatf("t3_beat%0d", k), 1'b1, 2'd2, 1'b1, 4'b0100, 16'h3000);
      if (fifo_wea) wr_cnt++;
      tick();
    end
    fifo_full = 1'b0;
    chk("t3_release", 1'b0, 2'd0, 1'b0, 4'b0000, 16'h0000);
    nchk++;
    if (wr_cnt != 8) begin
      nbad++;
      $display("FAIL t3_count: got %0d writes, want 8", wr_cnt);
    end

    // Test 4: req 1 drops valid after 3 beats while req 3 waits
    do_reset();
    req_valid = 4'b1010;
    wr_cnt = 0;
    chk("t4_arb", 1'b0, 2'd0, 1'b0, 4'b0000, 16'h0000);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t4_beat%0d", k), 1'b1, 2'd1, 1'b1, 4'b0010, 16'h2000);
      if (fifo_wea && grant_id == 2'd1) wr_cnt++;
      tick();
    end
    req_valid = 4'b1000;
    chk("t4_drop", 1'b1, 2'd1, 1'b0, 4'b0010, 16'h2000);
    tick();
    chk("t4_rearb", 1'b0, 2'd0, 1'b0, 4'b0000, 16'h0000);
    tick();
    chk("t4_grant3", 1'b1, 2'd3, 1'b1, 4'b1000, 16'h4000);
    nchk++;
    if (wr_cnt != 3) begin
      nbad++;
      $display("FAIL t4_count: got %0d writes, want 3", wr_cnt);
    end

    // Test 5: reset on beat 4 of req 0 drops grant; re-arbitration picks 0 again
    do_reset();
    req_valid = 4'b0011;
    chk("t5_arb", 1'b0, 2'd0, 1'b0, 4'b0000, 16'h0000);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t5_beat%0d", k), 1'b1, 2'd0, 1'b1, 4'b0001, 16'h1000);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_after_rst", 1'b0, 2'd0, 1'b0, 4'b0000, 16'h0000);
    tick();
    chk("t5_regrant", 1'b1, 2'd0, 1'b1, 4'b0001, 16'h1000);

    // Test 6: full in IDLE does not block arbitration
    do_reset();
    fifo_full = 1'b1;
    req_valid = 4'b0100;
    chk("t6_arb", 1'b0, 2'd0, 1'b0, 4'b0000, 16'h0000);
    tick();
    chk("t6_held0", 1'b1, 2'd2, 1'b0, 4'b0000, 16'h3000);
    tick();
    chk("t6_held1", 1'b1, 2'd2, 1'b0, 4'b0000, 16'h3000);
    tick();
    fifo_full = 1'b0;
    chk("t6_first_beat", 1'b1, 2'd2, 1'b1, 4'b0100, 16'h3000);
    tick();

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares one FIFO write port (wea/dina/full) among NREQ independent producers. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time and holds the grant for a burst of up to MAX_BURST beats. It sits directly in front of the FIFO write side; the FIFO full flag is the only backpressure source.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_W, 16, data word width in bits (matches FIFO dina width)
MAX_BURST, 8, maximum beats per grant (1..255)
IDW, 2, grant index width, = clog2(NREQ); set by integrator

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
req_valid  input  NREQ  per-requester data valid
req_data  input  NREQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W]
req_ready  output  NREQ  per-requester accept; a beat transfers when valid & ready
fifo_full  input  1  FIFO full flag
fifo_wea  output  1  FIFO write enable
fifo_dina  output  DATA_W  FIFO write data
grant_active  output  1  a burst is in progress (state BURST)
grant_id  output  IDW  index of granted requester; valid when grant_active=1

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE, grant_id=0, beat_cnt=0, last_ptr=NREQ-1 (requester 0 has top priority first). While reset is asserted and in IDLE: req_ready=0, fifo_wea=0, fifo_dina=0, grant_active=0. Reset mid-burst drops the grant on the next edge; no partial-burst bookkeeping survives.
- State IDLE:
  - No transfers; req_ready=0, fifo_wea=0.
  - If any req_valid: pick the first asserted index searching last_ptr+1, last_ptr+2, ... modulo NREQ.
  - Register grant_id=winner, beat_cnt=0, go to BURST. This costs one arbitration cycle.
  - fifo_full does not block arbitration.
- State BURST, with g=grant_id:
  - req_ready[g] = ~fifo_full; all other ready bits are 0.
  - fifo_wea = req_valid[g] & ~fifo_full (combinational, zero latency).
  - fifo_dina = req_data slice g whenever grant_active, else 0.
  - Beat: req_valid[g] & ~fifo_full. Each beat increments beat_cnt (8-bit, saturates irrelevant since it is bounded by MAX_BURST).
- Release conditions, evaluated at posedge in BURST:
  - (a) a beat occurs with beat_cnt==MAX_BURST-1;
  - (b) req_valid[g]==0 in that cycle; no transfer that cycle.
  - On release: last_ptr=g, state=IDLE.
- fifo_full=1 in BURST stalls: no beat, beat_cnt holds, grant is held. Full alone never releases a grant.
- A requester that keeps valid high after release is re-arbitrated fairly. It wins again only if no other requester is valid.
- Simultaneous requests are resolved purely by round-robin order. There is no starvation: worst-case wait is (NREQ-1)*(MAX_BURST+1) non-full cycles.
- Requester protocol: req_data must be held stable while valid & ~ready. The arbiter does not register data.
- The FIFO drop-on-full is never exercised: fifo_wea is never asserted while fifo_full=1.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=0, ST_BURST=1) and a clog2 function for IDW.
- One natural sub-module: rr_pick, a combinational round-robin priority picker. Inputs: req vector and last_ptr. Outputs: winner index and any_req. It is reused by later read-side schedulers.

Test Plan:
1. Reset, then req_valid=4'b0001 with data 0x1000..0x1009 and fifo_full=0 -> 1 idle cycle, then exactly 8 beats 0x1000..0x1007 on fifo_wea/fifo_dina; release; 1 arbitration cycle; beats 0x1008,0x1009.
2. req_valid=4'b1111 held continuously -> grant order 0,1,2,3,0. Each burst is 8 beats with one gap cycle between bursts. grant_id tracks the order.
3. Grant req 2; assert fifo_full for 5 cycles after beat 3 -> fifo_wea=0 and req_ready=0 for those 5 cycles; beat_cnt holds; burst resumes and completes 8 total beats under grant 2.
4. Grant req 1; drop req_valid[1] after 3 beats while req_valid[3]=1 -> release with no transfer; next grant is 3; 3 words are written for req 1.
5. Assert rst for 1 cycle mid-burst (beat 4 of req 0) -> next cycle grant_active=0 and fifo_wea=0; with req 0 and req 1 valid, the re-arbitration grants req 0 (last_ptr reset to NREQ-1).
6. fifo_full=1 while in IDLE with req_valid=4'b0100 -> grant 2 asserted and grant_active=1, fifo_wea stays 0; deassert full -> first beat on that cycle.
